router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-reception controller for the 1x3 router; sits between the input port, the register block and router_sync.
- Decodes the 2-bit destination address from the header and sequences header, payload and parity loading.
- Handles back-pressure from full FIFOs and soft resets issued by router_sync.
- Drives detect_add and write_enb_reg into router_sync, and the load/state strobes into the register block.

Parameters:
- None. Port count is fixed at 3 and the address is fixed at 2 bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pkt_valid  input  1  packet byte valid on the input bus.
- data_in  input  2  header address bits [1:0] from the input bus.
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  register block flags that pkt_valid fell while the FIFO was full.
- fifo_full  input  1  selected FIFO full (from router_sync).
- fifo_empty_0/1/2  input  1 each  FIFO n empty.
- soft_reset_0/1/2  input  1 each  soft reset of FIFO n (from router_sync).
- detect_add  output  1  in DECODE_ADDRESS.
- lfd_state  output  1  in LOAD_FIRST_DATA.
- ld_state  output  1  in LOAD_DATA.
- laf_state  output  1  in LOAD_AFTER_FULL.
- full_state  output  1  in FIFO_FULL_STATE.
- write_enb_reg  output  1  FIFO write permitted.
- rst_int_reg  output  1  in CHECK_PARITY_ERROR.
- busy  output  1  input port must stall.

Behaviour:
- States: DA (DECODE_ADDRESS), LFD (LOAD_FIRST_DATA), LD (LOAD_DATA), FFS (FIFO_FULL_STATE), LAF (LOAD_AFTER_FULL), LP (LOAD_PARITY), CPE (CHECK_PARITY_ERROR), WTE (WAIT_TILL_EMPTY).
- State register updates on the rising clock edge.
- reset (async) forces state DA and addr_q=2'b00.
- Outputs are Moore, decoded from the state only.
  - Reset values: detect_add=1; all other outputs 0.
- addr_q (2 bits) loads data_in whenever state==DA and pkt_valid=1 and data_in!=2'b11.
- Transitions, highest priority first:
  - Soft reset: if state!=DA and soft_reset_[addr_q]=1, next state = DA. This overrides every transition below.
  - DA:
    - pkt_valid && data_in==n && fifo_empty_n -> LFD.
    - pkt_valid && data_in==n && !fifo_empty_n -> WTE.
    - data_in==2'b11 or !pkt_valid -> stay in DA.
  - WTE: fifo_empty_[addr_q] -> LFD, else stay.
  - LFD -> LD unconditionally (one cycle).
  - LD:
    - fifo_full -> FFS.
    - else !pkt_valid -> LP.
    - else stay.
  - FFS: !fifo_full -> LAF, else stay.
  - LAF:
    - parity_done -> DA.
    - else low_pkt_valid -> LP.
    - else -> LD.
  - LP -> CPE unconditionally.
  - CPE: fifo_full -> FFS, else -> DA.
- Output decode:
  - detect_add = (DA); lfd_state = (LFD); ld_state = (LD); laf_state = (LAF); full_state = (FFS); rst_int_reg = (CPE).
  - write_enb_reg = LD | LP | LAF.
  - busy = 1 in every state except DA and LD.
- Latency:
  - Header accepted in DA at edge k gives LFD at k+1 and LD at k+2.
  - Shortest packet is DA, LFD, LD, LP, CPE, DA: 5 cycles header-to-return.
- Simultaneous events:
  - Soft reset wins over fifo_full and pkt_valid.
  - In LD, fifo_full wins over a falling pkt_valid.
- An illegal state encoding recovers to DA on the next edge.
- Reset mid-packet returns to DA immediately, asynchronously; no partial strobes are held.

Test Plan:
- Reset → state DA, detect_add=1, busy=0, write_enb_reg=0; hold 3 cycles with pkt_valid=0 and confirm it stays in DA.
- Header data_in=2'b01, pkt_valid=1, fifo_empty_1=1 → next cycles LFD (lfd_state=1, busy=1), then LD (ld_state=1, write_enb_reg=1, busy=0). Drop pkt_valid → LP, then CPE (rst_int_reg=1), then DA.
- Header data_in=2'b10 with fifo_empty_2=0 for 4 cycles → WTE, busy=1, write_enb_reg=0. Raise fifo_empty_2 → LFD next cycle.
- In LD, assert fifo_full for 3 cycles → FFS (full_state=1, write_enb_reg=0). Deassert fifo_full → LAF (laf_state=1).
  - With low_pkt_valid=1, parity_done=0 → LP.
  - Repeat with low_pkt_valid=0 → LD.
  - Repeat with parity_done=1 → DA.
- In LD with addr_q=0, pulse soft_reset_0 together with fifo_full=1 → DA next cycle. soft_reset_1 in the same situation → FFS (no effect).
- Header data_in=2'b11, pkt_valid=1 → stays in DA and addr_q is unchanged. Assert reset asynchronously while in LD → DA without waiting for a clock edge.

Source files
------------

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet-reception controller FSM for the 1x3 router
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic       empty_hdr;   // empty flag of the FIFO addressed by the incoming header
  logic       empty_addr;  // empty flag of the latched destination FIFO
  logic       soft_addr;   // soft reset of the latched destination FIFO

  // Select per-port flags by the live header address and by the latched address
  always_comb begin
    empty_hdr  = 1'b0;
    empty_addr = 1'b0;
    soft_addr  = 1'b0;
    case (data_in)
      2'b00:   empty_hdr = fifo_empty_0;
      2'b01:   empty_hdr = fifo_empty_1;
      2'b10:   empty_hdr = fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
    case (addr_q)
      2'b00: begin
        empty_addr = fifo_empty_0;
        soft_addr  = soft_reset_0;
      end
      2'b01: begin
        empty_addr = fifo_empty_1;
        soft_addr  = soft_reset_1;
      end
      2'b10: begin
        empty_addr = fifo_empty_2;
        soft_addr  = soft_reset_2;
      end
      default: begin
        empty_addr = 1'b0;
        soft_addr  = 1'b0;
      end
    endcase
  end

  // Next-state and address-latch logic; soft reset of the active port overrides everything
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DA && pkt_valid && data_in != 2'b11) begin
      addr_d = data_in;
    end
    case (state_q)
      DA: begin
        if (pkt_valid && data_in != 2'b11) begin
          state_d = empty_hdr ? LFD : WTE;
        end
      end
      WTE:     state_d = empty_addr ? LFD : WTE;
      LFD:     state_d = LD;
      LD: begin
        if (fifo_full)       state_d = FFS;
        else if (!pkt_valid) state_d = LP;
        else                 state_d = LD;
      end
      FFS:     state_d = fifo_full ? FFS : LAF;
      LAF: begin
        if (parity_done)        state_d = DA;
        else if (low_pkt_valid) state_d = LP;
        else                    state_d = LD;
      end
      LP:      state_d = CPE;
      CPE:     state_d = fifo_full ? FFS : DA;
      default: state_d = DA;
    endcase
    if (state_q != DA && soft_addr) begin
      state_d = DA;
    end
  end

  // State and destination-address registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DA;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore output decode from the current state
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state_q)
      DA: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LFD: lfd_state = 1'b1;
      LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FFS: full_state = 1'b1;
      LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LP:  write_enb_reg = 1'b1;
      CPE: rst_int_reg = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - self-checking bench for router_fsm
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int checks = 0;
  int errors = 0;

  // Expected output vectors {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}
  localparam logic [7:0] S_DA  = 8'b1000_0000;
  localparam logic [7:0] S_LFD = 8'b0100_0001;
  localparam logic [7:0] S_LD  = 8'b0010_0100;
  localparam logic [7:0] S_LAF = 8'b0001_0101;
  localparam logic [7:0] S_FFS = 8'b0000_1001;
  localparam logic [7:0] S_LP  = 8'b0000_0101;
  localparam logic [7:0] S_CPE = 8'b0000_0011;
  localparam logic [7:0] S_WTE = 8'b0000_0001;

  typedef struct packed {
    logic [11:0] in;
    logic [7:0]  exp;
  } row_t;

  logic [7:0] exp_q[$];
  logic [7:0] outs;
  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 write_enb_reg, rst_int_reg, busy};

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [11:0] mk(input logic pv, input logic [1:0] din,
                                     input logic pd, input logic low, input logic full,
                                     input logic [2:0] fe, input logic [2:0] sr);
    return {pv, din, pd, low, full, fe, sr};
  endfunction

  task automatic apply(input logic [11:0] v);
    pkt_valid     = v[11];
    data_in       = v[10:9];
    parity_done   = v[8];
    low_pkt_valid = v[7];
    fifo_full     = v[6];
    fifo_empty_2  = v[5];
    fifo_empty_1  = v[4];
    fifo_empty_0  = v[3];
    soft_reset_2  = v[2];
    soft_reset_1  = v[1];
    soft_reset_0  = v[0];
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [7:0] e;
    apply(mk(0, 0, 0, 0, 0, 3'b111, 3'b000));
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== S_DA) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", outs, S_DA);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_DA});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, outs, e);
      end
    end
  endtask

  task automatic test_basic();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_LP});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_CPE});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_DA});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL basic[%0d]: got %b expected %b", i, outs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_LP});
    rows.push_back({mk(1, 2, 0, 0, 0, 3'b111, 3'b000), S_CPE});
    rows.push_back({mk(1, 2, 0, 0, 0, 3'b111, 3'b000), S_DA});
    rows.push_back({mk(1, 2, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 2, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_LP});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_CPE});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_DA});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, outs, e);
      end
    end
  endtask

  task automatic test_illegal_header();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 3, 0, 0, 0, 3'b111, 3'b000));
      exp_q.push_back(S_DA);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL illegal_header[%0d]: got %b expected %b", i, outs, e);
      end
    end
    checks++;
    if (dut.addr_q !== 2'b10) begin
      errors++;
      $display("FAIL illegal_header_addr: got %b expected %b", dut.addr_q, 2'b10);
    end
  endtask

  task automatic test_wait_empty();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back({mk(1, 2, 0, 0, 0, 3'b011, 3'b000), S_WTE});
    for (int i = 0; i < 3; i++) rows.push_back({mk(0, 0, 0, 0, 0, 3'b011, 3'b000), S_WTE});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_LP});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_CPE});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_DA});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL wait_empty[%0d]: got %b expected %b", i, outs, e);
      end
    end
  endtask

  task automatic test_fifo_full();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LD});
    for (int i = 0; i < 3; i++) rows.push_back({mk(1, 0, 0, 0, 1, 3'b111, 3'b000), S_FFS});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_LAF});
    rows.push_back({mk(0, 0, 0, 1, 0, 3'b111, 3'b000), S_LP});
    rows.push_back({mk(0, 0, 0, 0, 1, 3'b111, 3'b000), S_CPE});
    rows.push_back({mk(0, 0, 0, 0, 1, 3'b111, 3'b000), S_FFS});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LAF});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(0, 0, 0, 0, 1, 3'b111, 3'b000), S_FFS});
    rows.push_back({mk(0, 0, 0, 0, 0, 3'b111, 3'b000), S_LAF});
    rows.push_back({mk(0, 0, 1, 1, 0, 3'b111, 3'b000), S_DA});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL fifo_full[%0d]: got %b expected %b", i, outs, e);
      end
    end
  endtask

  task automatic test_soft_reset();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(1, 0, 0, 0, 1, 3'b111, 3'b001), S_DA});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LD});
    rows.push_back({mk(1, 0, 0, 0, 1, 3'b111, 3'b010), S_FFS});
    rows.push_back({mk(1, 0, 0, 0, 0, 3'b111, 3'b000), S_LAF});
    rows.push_back({mk(0, 0, 1, 0, 0, 3'b111, 3'b000), S_DA});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL soft_reset[%0d]: got %b expected %b", i, outs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LFD});
    rows.push_back({mk(1, 1, 0, 0, 0, 3'b111, 3'b000), S_LD});
    foreach (rows[i]) begin
      apply(rows[i].in);
      exp_q.push_back(rows[i].exp);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL async_reset_setup[%0d]: got %b expected %b", i, outs, e);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== S_DA) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", outs, S_DA);
    end
    checks++;
    if (dut.addr_q !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_addr: got %b expected %b", dut.addr_q, 2'b00);
    end
    #2;
    reset = 1'b0;
    apply(mk(1, 1, 0, 0, 0, 3'b111, 3'b000));
    exp_q.push_back(S_LD);
    @(posedge clock); #1;
    exp_q.pop_front();
    exp_q.push_back(S_LFD);
    e = exp_q.pop_front();
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL async_reset_restart: got %b expected %b", outs, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal_header();
    test_wait_empty();
    test_fifo_full();
    test_soft_reset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
